// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end, upstream of decode.
//
// Owns the PC and issues in-order fetches over a valid/ready request channel.
// Responses return in request order and may have any latency. Each response is
// paired with its PC from a tag queue and buffered in a small FIFO. The FIFO
// head is the IF/ID boundary.
//
// A redirect flushes the FIFO. Responses still in flight are counted in `drop`
// and discarded when they arrive. Requests are throttled by a credit rule, so
// every live in-flight response always has a FIFO slot waiting for it.
//
// Ports:
//   clk, reset                          clock; asynchronous active-high reset
//   imem_req_valid/ready/addr           fetch request channel (addr = pc)
//   imem_rsp_valid/data                 in-order instruction responses
//   stall                               decode holds the head entry
//   redirect_valid/redirect_pc          EX-stage redirect (highest priority)
//   id_valid/id_instr/id_pc/id_pc_plus4 FIFO head presented to decode
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_fetched, perf_dropped and perf_stall_cycles.
module fetch_stage #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_stall_cycles
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0] pc;
    logic [OCW-1:0]  outstanding;
    logic [OCW-1:0]  drop;

    logic [XLEN-1:0] tag_mem [MAX_OUTSTANDING];
    logic [TPW-1:0]  tag_wr;
    logic [TPW-1:0]  tag_rd;

    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [FPW-1:0]  fifo_wr;
    logic [FPW-1:0]  fifo_rd;
    logic [FCW-1:0]  fifo_count;

    logic accept;
    logic fifo_push;
    logic fifo_pop;
    logic rsp_discard;

    function automatic logic [FPW-1:0] fifo_next(input logic [FPW-1:0] p);
        return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + FPW'(1);
    endfunction

    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TPW'(1);
    endfunction

    // Credit rule: live in-flight requests (outstanding minus those already
    // marked for discard) plus queued entries must leave a free FIFO slot.
    // Reset is folded in so that no request is shown while reset is held.
    always_comb begin
        imem_req_valid = !reset && !redirect_valid
                         && (32'(outstanding) < MAX_OUTSTANDING)
                         && (32'(outstanding - drop) + 32'(fifo_count) < FIFO_DEPTH);
    end

    assign imem_req_addr = pc;
    assign accept        = imem_req_valid && imem_req_ready;

    // A response landing in a redirect cycle belongs to the old path.
    assign rsp_discard = imem_rsp_valid && (redirect_valid || drop != '0);
    assign fifo_push   = imem_rsp_valid && !redirect_valid && drop == '0;
    assign fifo_pop    = id_valid && !stall && !redirect_valid;

    assign id_valid    = fifo_count != '0;
    assign id_instr    = id_valid ? fifo_instr[fifo_rd] : NOP;
    assign id_pc       = id_valid ? fifo_pc[fifo_rd] : '0;
    assign id_pc_plus4 = id_pc + XLEN'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
        end else begin
            outstanding <= outstanding + OCW'(accept) - OCW'(imem_rsp_valid);
            if (accept)
                tag_wr <= tag_next(tag_wr);
            if (imem_rsp_valid)
                tag_rd <= tag_next(tag_rd);

            if (redirect_valid) begin
                pc         <= redirect_pc;
                drop       <= outstanding - OCW'(imem_rsp_valid);
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                fifo_count <= '0;
            end else begin
                if (accept)
                    pc <= pc + XLEN'(4);
                if (imem_rsp_valid && drop != '0)
                    drop <= drop - OCW'(1);
                if (fifo_push)
                    fifo_wr <= fifo_next(fifo_wr);
                if (fifo_pop)
                    fifo_rd <= fifo_next(fifo_rd);
                case ({fifo_push, fifo_pop})
                    2'b10:   fifo_count <= fifo_count + FCW'(1);
                    2'b01:   fifo_count <= fifo_count - FCW'(1);
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[tag_wr] <= pc;
        if (fifo_push) begin
            fifo_pc[fifo_wr]    <= tag_mem[tag_rd];
            fifo_instr[fifo_wr] <= imem_rsp_data;
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && !fifo_pop && 32'(fifo_count) == FIFO_DEPTH));

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && outstanding == '0));

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_dropped      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (fifo_push && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (rsp_discard && perf_dropped != '1)
                perf_dropped <= perf_dropped + 32'd1;
            if (stall && id_valid && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
//
// The reference model works at the level of fetch paths. Each request is
// stamped with the epoch in effect when it is accepted, and a redirect starts
// a new epoch. A response is delivered only if it belongs to the current epoch
// and no redirect occurs that cycle. The decode queue is a plain queue.
module tb_fetch_stage;

    localparam int          XLEN   = 32;
    localparam int          FD     = 2;
    localparam int          MO     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN(XLEN), .RESET_PC(RST_PC), .FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] m_pc;
    int          epoch;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          rdy_pct, rsp_pct, max_lat, stall_pct, redir_pct;
    int          m_fetched, m_dropped, m_stalls;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    // One clock cycle: drive inputs at negedge, check outputs, update model at posedge.
    // redir/stall_f: -1 = random, 0/1 = forced.
    task automatic step(input int redir, input logic [31:0] tgt, input int stall_f);
        bit   rsp, acc, exp_valid, do_pop;
        int   live;
        req_t h;
        @(negedge clk);
        cyc++;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        rsp = (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
        stall          = (stall_f < 0) ? ($urandom_range(99) < stall_pct) : stall_f[0];
        redirect_valid = (redir < 0) ? ($urandom_range(99) < redir_pct) : redir[0];
        redirect_pc    = tgt;
        #1;
        live = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) live++;
        exp_valid = !redirect_valid && (pend.size() < MO) && (live + mq.size() < FD);

        n_checks++;
        if (imem_req_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL req_valid cyc=%0d got %0b expected %0b", cyc, imem_req_valid, exp_valid);
        end
        n_checks++;
        if (imem_req_addr !== m_pc) begin
            n_fail++;
            $display("FAIL req_addr cyc=%0d got %h expected %h", cyc, imem_req_addr, m_pc);
        end
        n_checks++;
        if (id_valid !== (mq.size() != 0)) begin
            n_fail++;
            $display("FAIL id_valid cyc=%0d got %0b expected %0b", cyc, id_valid, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            n_checks++;
            if (id_pc !== mq[0].pc || id_instr !== mq[0].instr || id_pc_plus4 !== mq[0].pc + 32'd4) begin
                n_fail++;
                $display("FAIL id_entry cyc=%0d got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                         cyc, id_pc, id_instr, id_pc_plus4, mq[0].pc, mq[0].instr, mq[0].pc + 32'd4);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetched !== 32'(m_fetched) || perf_dropped !== 32'(m_dropped)
            || perf_stall_cycles !== 32'(m_stalls)) begin
            n_fail++;
            $display("FAIL perf cyc=%0d got %0d/%0d/%0d expected %0d/%0d/%0d", cyc,
                     perf_fetched, perf_dropped, perf_stall_cycles, m_fetched, m_dropped, m_stalls);
        end
`endif
        acc = exp_valid && imem_req_ready;
        if (stall && mq.size() != 0) m_stalls++;

        @(posedge clk);
        do_pop = !redirect_valid && mq.size() != 0 && !stall;
        if (do_pop) void'(mq.pop_front());
        if (rsp) begin
            h = pend.pop_front();
            if (redirect_valid || h.epoch != epoch) begin
                m_dropped++;
            end else begin
                mq.push_back('{pc: h.addr, instr: mem_word(h.addr)});
                m_fetched++;
            end
        end
        n_checks++;
        if (mq.size() > FD) begin
            n_fail++;
            $display("FAIL queue_overflow cyc=%0d got %0d entries expected at most %0d", cyc, mq.size(), FD);
        end
        if (redirect_valid) begin
            mq.delete();
            epoch++;
            m_pc = tgt;
        end else if (acc) begin
            pend.push_back('{addr: m_pc, epoch: epoch, due: cyc + 1 + int'($urandom_range(max_lat))});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP
            || id_pc !== 32'h0 || id_pc_plus4 !== 32'h4) begin
            n_fail++;
            $display("FAIL %s got req_valid=%0b id_valid=%0b instr=%h pc=%h pc4=%h expected 0 0 %h 0 4",
                     tag, imem_req_valid, id_valid, id_instr, id_pc, id_pc_plus4, NOP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (perf_fetched !== 32'h0 || perf_dropped !== 32'h0 || perf_stall_cycles !== 32'h0) begin
            n_fail++;
            $display("FAIL %s_perf got %0d/%0d/%0d expected 0/0/0", tag,
                     perf_fetched, perf_dropped, perf_stall_cycles);
        end
`endif
    endtask

    task automatic clear_model();
        pend.delete();
        mq.delete();
        m_pc = RST_PC;
        epoch++;
        m_fetched = 0;
        m_dropped = 0;
        m_stalls  = 0;
    endtask

    task automatic set_mode(input int rdy, input int rsp, input int lat, input int stl, input int rdr);
        rdy_pct = rdy; rsp_pct = rsp; max_lat = lat; stall_pct = stl; redir_pct = rdr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #1;
        check_reset_outputs("reset_state");
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        set_mode(100, 100, 0, 0, 0);
        repeat (20) step(0, '0, 0);
    endtask

    task automatic test_stall();
        set_mode(100, 100, 0, 0, 0);
        repeat (5) step(0, '0, 1);
        repeat (10) step(0, '0, 0);
    endtask

    task automatic test_redirect_inflight();
        set_mode(0, 100, 0, 0, 0);
        repeat (6) step(0, '0, 0);
        set_mode(100, 0, 0, 0, 0);
        repeat (3) step(0, '0, 0);
        step(1, 32'h0000_0100, 0);
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_req_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redirect_flush got id_valid=%0b addr=%h expected 0 00000100", id_valid, imem_req_addr);
        end
        set_mode(100, 100, 0, 0, 0);
        repeat (12) step(0, '0, 0);
    endtask

    task automatic test_redirect_rsp_stall();
        set_mode(100, 100, 0, 0, 0);
        repeat (4) step(0, '0, 0);
        step(1, 32'h0000_0200, 1);
        #1;
        n_checks++;
        if (id_valid !== 1'b0 || imem_req_addr !== 32'h0000_0200) begin
            n_fail++;
            $display("FAIL redirect_stall got id_valid=%0b addr=%h expected 0 00000200", id_valid, imem_req_addr);
        end
        repeat (10) step(0, '0, 0);
    endtask

    task automatic test_ready_low_wrap();
        set_mode(0, 100, 0, 0, 0);
        repeat (4) step(0, '0, 0);
        step(1, 32'hFFFF_FFF8, 0);
        set_mode(100, 100, 0, 0, 0);
        repeat (12) step(0, '0, 0);
        step(1, 32'h0000_0042, 0);
        repeat (8) step(0, '0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0)
                set_mode(30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
                         int'($urandom_range(3)), int'($urandom_range(40)), 3);
            step(-1, ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC), -1);
        end
    endtask

    task automatic test_mid_reset();
        set_mode(0, 100, 0, 0, 0);
        repeat (6) step(0, '0, 0);
        set_mode(100, 0, 0, 30, 0);
        repeat (3) step(0, '0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        stall = 1'b0; redirect_valid = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        set_mode(100, 100, 1, 0, 0);
        repeat (15) step(0, '0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        epoch    = 0;
        cyc      = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_rsp_stall();
        test_ready_low_wrap();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
